// File: rtl/key_code_capture_if.sv
// ---------------------------------------------------------------------------
// key_code_capture_if
// Bundles the key encoder inputs and the code FIFO output stream of
// key_code_capture.
//   y_in, valid_in : raw 2-bit key code and key-down flag (asynchronous)
//   out_code       : code at the FIFO head
//   out_valid      : FIFO not empty
//   out_ready      : consumer accept; pop when out_valid && out_ready
//   fifo_count     : FIFO occupancy
//   overflow       : sticky "code dropped" flag
//   ovf_clr        : synchronous clear of overflow
// Modports: master = encoder/consumer side, slave = capture block.
// ---------------------------------------------------------------------------
interface key_code_capture_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [1:0]                    y_in;
    logic                          valid_in;
    logic [1:0]                    out_code;
    logic                          out_valid;
    logic                          out_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;
    logic                          ovf_clr;

    modport master (
        output y_in, valid_in, out_ready, ovf_clr,
        input  out_code, out_valid, fifo_count, overflow
    );

    modport slave (
        input  y_in, valid_in, out_ready, ovf_clr,
        output out_code, out_valid, fifo_count, overflow
    );
endinterface

// File: rtl/key_code_capture.sv
// ---------------------------------------------------------------------------
// key_code_capture
// Synchronizes a 2-bit key code from a priority encoder, debounces press and
// release, and queues each accepted press code into a small FIFO.
// Ports:
//   clk   : clock, all state updates on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : key_code_capture_if.slave (encoder inputs, FIFO output stream,
//           occupancy, sticky overflow and its clear)
// Parameters: DEBOUNCE_CYCLES (2..255), FIFO_DEPTH (power of two, 2..16),
//   REPEAT_CYCLES (auto-repeat interval).
// Macro KEY_CAPTURE_REPEAT_EN: when defined, a held key re-pushes its code
//   every REPEAT_CYCLES cycles while in PRESSED; when undefined, exactly one
//   push per accepted press.
// ---------------------------------------------------------------------------
module key_code_capture #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_CYCLES   = 1024
) (
    input logic            clk,
    input logic            rst_n,
    key_code_capture_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] DEB_PRESS   = 2'd1;
    localparam logic [1:0] PRESSED     = 2'd2;
    localparam logic [1:0] DEB_RELEASE = 2'd3;

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // ---------------- 2-flop synchronizers ----------------
    logic [1:0] code_meta_q, s_code_q;
    logic       valid_meta_q, s_valid_q;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of the others; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_meta_q  <= 2'b00;
            s_code_q     <= 2'b00;
            valid_meta_q <= 1'b0;
            s_valid_q    <= 1'b0;
        end else begin
            code_meta_q  <= bus.y_in;
            s_code_q     <= code_meta_q;
            valid_meta_q <= bus.valid_in;
            s_valid_q    <= valid_meta_q;
        end
    end

    // ---------------- Debounce FSM ----------------
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] cap_code_q, cap_code_d;
    logic       push;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_code_d = cap_code_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid_q) begin
                    cap_code_d = s_code_q;
                    cnt_d      = 8'd1;
                    state_d    = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (!s_valid_q) begin
                    state_d = IDLE;
                end else if (s_code_q != cap_code_q) begin
                    // Code moved while settling: restart on the new code.
                    cap_code_d = s_code_q;
                    cnt_d      = 8'd1;
                end else if (cnt_q == DEB_LAST) begin
                    push    = 1'b1;
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PRESSED: begin
                if (!s_valid_q) begin
                    cnt_d   = 8'd1;
                    state_d = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                if (s_valid_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            cap_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_code_q <= cap_code_d;
        end
    end

    // ---------------- Optional auto-repeat ----------------
    logic push_any;

`ifdef KEY_CAPTURE_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_push;

    // Held at zero outside PRESSED, so every entry into PRESSED starts fresh.
    always_comb begin
        rpt_d    = '0;
        rpt_push = 1'b0;
        if (state_q == PRESSED) begin
            if (rpt_q == RPT_LAST) begin
                rpt_push = 1'b1;
            end else begin
                rpt_d = rpt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rpt_q <= '0;
        else        rpt_q <= rpt_d;
    end

    assign push_any = push | rpt_push;
`else
    assign push_any = push;
`endif

    // ---------------- Code FIFO ----------------
    logic [1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       out_code_q, head_d;
    logic             out_valid_q, overflow_q, overflow_d;
    logic             pop, full, push_ok, drop;

    assign pop     = out_valid_q && bus.out_ready;
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok = push_any && (!full || pop);
    assign drop    = push_any && full && !pop;

    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Register the next head; when the FIFO is empty after this edge's
        // pop, the entry being written is the new head and must bypass mem_q.
        head_d = 2'b00;
        if (count_d != '0) begin
            if (push_ok && count_q == CNT_W'(pop)) head_d = cap_code_q;
            else                                   head_d = mem_q[rd_ptr_d];
        end
        // Set wins over a same-cycle clear.
        overflow_d = drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : overflow_q);
    end

    // NOTE: storage has no reset; the pointers and count define what is
    // valid, and the registered head is reset separately.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= cap_code_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_code_q  <= 2'b00;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            count_q     <= count_d;
            out_code_q  <= head_d;
            out_valid_q <= (count_d != '0);
            overflow_q  <= overflow_d;
        end
    end

    assign bus.out_code   = out_code_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;

endmodule
